// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage redirect controller: owns the PC, arbitrates branch/jump/exception/halt
// redirects against stalls, defers redirects that arrive under MemWait and replays them.
module fetch_redirect_ctrl #(
    parameter int                   DataWidth   = 16,
    parameter logic [DataWidth-1:0] ResetVector = '0
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [DataWidth-1:0] NextPC,
    input  logic                 BranchResolved,
    input  logic                 BranchTaken,
    input  logic [DataWidth-1:0] BranchTarget,
    input  logic                 JumpValid,
    input  logic [DataWidth-1:0] JumpTarget,
    input  logic                 OverwriteReq,
    input  logic [DataWidth-1:0] OverwriteVector,
    input  logic                 HaltInstr,
    input  logic                 ResumeReq,
    input  logic                 LoadUseHazard,
    input  logic                 MemWait,
    output logic [DataWidth-1:0] PC,
    output logic                 TakeBranch,
    output logic                 TakeJump,
    output logic                 PCOverwrite,
    output logic                 Halt,
    output logic                 Stall,
    output logic [DataWidth-1:0] OverwriteAddress,
    output logic                 FlushIF,
    output logic                 FlushID,
    output logic                 FlushEX,
    output logic [DataWidth-1:0] StallCount
);

    typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;

    state_t               state, nextState;
    logic [DataWidth-1:0] pendTarget, pendNext;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            PC         <= ResetVector;
            state      <= RUN;
            pendTarget <= '0;
            StallCount <= '0;
        end else begin
            PC         <= NextPC;
            state      <= nextState;
            pendTarget <= pendNext;
            if (Stall && StallCount != '1)
                StallCount <= StallCount + DataWidth'(1);
        end
    end

    always_comb begin
        TakeBranch       = 1'b0;
        TakeJump         = 1'b0;
        PCOverwrite      = 1'b0;
        Halt             = 1'b0;
        Stall            = 1'b0;
        FlushIF          = 1'b0;
        FlushID          = 1'b0;
        FlushEX          = 1'b0;
        OverwriteAddress = OverwriteVector;
        nextState        = state;
        pendNext         = pendTarget;

        unique case (state)
            PEND: begin
                if (MemWait) begin
                    Stall = 1'b1;
                    if (OverwriteReq) begin
                        pendNext = OverwriteVector;
                        FlushIF  = 1'b1;
                        FlushID  = 1'b1;
                        FlushEX  = 1'b1;
                    end
                end else begin
                    PCOverwrite      = 1'b1;
                    OverwriteAddress = pendTarget;
                    nextState        = RUN;
                end
            end
            default: begin
                // Redirects (flushes always issued) are diverted into PEND while memory waits
                if (OverwriteReq) begin
                    FlushIF   = 1'b1;
                    FlushID   = 1'b1;
                    FlushEX   = 1'b1;
                    nextState = RUN;
                    if (MemWait) begin
                        Stall     = 1'b1;
                        pendNext  = OverwriteVector;
                        nextState = PEND;
                    end else begin
                        PCOverwrite = 1'b1;
                    end
                end else if (state == HALTED) begin
                    if (ResumeReq) nextState = RUN;
                    else           Halt      = 1'b1;
                end else if (BranchResolved && BranchTaken) begin
                    FlushIF = 1'b1;
                    FlushID = 1'b1;
                    if (MemWait) begin
                        Stall     = 1'b1;
                        pendNext  = BranchTarget;
                        nextState = PEND;
                    end else begin
                        TakeBranch = 1'b1;
                    end
                end else if (JumpValid) begin
                    FlushIF = 1'b1;
                    if (MemWait) begin
                        Stall     = 1'b1;
                        pendNext  = JumpTarget;
                        nextState = PEND;
                    end else begin
                        TakeJump = 1'b1;
                    end
                end else if (HaltInstr) begin
                    Halt      = 1'b1;
                    FlushIF   = 1'b1;
                    nextState = HALTED;
                end else if (LoadUseHazard || MemWait) begin
                    Stall = 1'b1;
                end
            end
        endcase

        if (!Reset_n) begin
            TakeBranch  = 1'b0;
            TakeJump    = 1'b0;
            PCOverwrite = 1'b0;
            Halt        = 1'b0;
            Stall       = 1'b0;
            FlushIF     = 1'b0;
            FlushID     = 1'b0;
            FlushEX     = 1'b0;
            OverwriteAddress = OverwriteVector;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: a behavioural model predicts every cycle's
// outputs, a separate monitor pops and compares them at the falling edge.
module tb_fetch_redirect_ctrl;

    localparam int DW = 8;

    logic          Clock;
    logic          Reset_n;
    logic [DW-1:0] NextPC;
    logic          BranchResolved, BranchTaken, JumpValid, OverwriteReq;
    logic          HaltInstr, ResumeReq, LoadUseHazard, MemWait;
    logic [DW-1:0] BranchTarget, JumpTarget, OverwriteVector;
    logic [DW-1:0] PC, OverwriteAddress, StallCount;
    logic          TakeBranch, TakeJump, PCOverwrite, Halt, Stall;
    logic          FlushIF, FlushID, FlushEX;

    fetch_redirect_ctrl #(.DataWidth(DW), .ResetVector(8'd0)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .NextPC(NextPC),
        .BranchResolved(BranchResolved), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .JumpValid(JumpValid), .JumpTarget(JumpTarget),
        .OverwriteReq(OverwriteReq), .OverwriteVector(OverwriteVector),
        .HaltInstr(HaltInstr), .ResumeReq(ResumeReq),
        .LoadUseHazard(LoadUseHazard), .MemWait(MemWait),
        .PC(PC), .TakeBranch(TakeBranch), .TakeJump(TakeJump), .PCOverwrite(PCOverwrite),
        .Halt(Halt), .Stall(Stall), .OverwriteAddress(OverwriteAddress),
        .FlushIF(FlushIF), .FlushID(FlushID), .FlushEX(FlushEX), .StallCount(StallCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        bit            known;
        logic [DW-1:0] pc, addr, cnt;
        logic          tb, tj, ov, halt, stall, fif, fid, fex;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   stimDone = 1'b0;

    // Reference model: halted / pending flags plus saved target, PC and counter
    bit            mKnown = 1'b0, mHalted = 1'b0, mPend = 1'b0;
    logic [DW-1:0] mTarget = '0, mPC = '0, mCnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic drive(input bit rst, input bit br, input bit bt, input logic [DW-1:0] btgt,
                         input bit jv, input logic [DW-1:0] jt, input bit ov,
                         input logic [DW-1:0] ovv, input bit hi, input bit rr,
                         input bit lu, input bit mw);
        exp_t          e;
        bit            nHalted, nPend;
        logic [DW-1:0] nTarget, nPC;
        Reset_n = rst; BranchResolved = br; BranchTaken = bt; BranchTarget = btgt;
        JumpValid = jv; JumpTarget = jt; OverwriteReq = ov; OverwriteVector = ovv;
        HaltInstr = hi; ResumeReq = rr; LoadUseHazard = lu; MemWait = mw;
        e = '{known: mKnown, pc: mPC, addr: ovv, cnt: mCnt, default: 1'b0};
        nHalted = mHalted; nPend = mPend; nTarget = mTarget;
        if (!rst) begin
        end else if (mPend) begin
            if (mw) begin
                e.stall = 1'b1;
                if (ov) begin nTarget = ovv; e.fif = 1'b1; e.fid = 1'b1; e.fex = 1'b1; end
            end else begin
                e.ov = 1'b1; e.addr = mTarget; nPend = 1'b0;
            end
        end else if (ov) begin
            e.fif = 1'b1; e.fid = 1'b1; e.fex = 1'b1; nHalted = 1'b0;
            if (mw) begin e.stall = 1'b1; nPend = 1'b1; nTarget = ovv; end
            else e.ov = 1'b1;
        end else if (mHalted) begin
            if (rr) nHalted = 1'b0; else e.halt = 1'b1;
        end else if (br && bt) begin
            e.fif = 1'b1; e.fid = 1'b1;
            if (mw) begin e.stall = 1'b1; nPend = 1'b1; nTarget = btgt; end
            else e.tb = 1'b1;
        end else if (jv) begin
            e.fif = 1'b1;
            if (mw) begin e.stall = 1'b1; nPend = 1'b1; nTarget = jt; end
            else e.tj = 1'b1;
        end else if (hi) begin
            e.halt = 1'b1; e.fif = 1'b1; nHalted = 1'b1;
        end else if (lu || mw) begin
            e.stall = 1'b1;
        end
        if (e.tb) nPC = btgt;
        else if (e.tj) nPC = jt;
        else if (e.ov) nPC = e.addr;
        else if (e.halt || e.stall) nPC = mPC;
        else nPC = mPC + DW'(1);
        NextPC = mKnown ? nPC : '0;
        expQ.push_back(e);
        @(posedge Clock);
        if (!rst) begin
            mKnown = 1'b1; mPC = '0; mCnt = '0; mHalted = 1'b0; mPend = 1'b0;
        end else begin
            mPC = nPC;
            if (e.stall && mCnt != '1) mCnt = mCnt + DW'(1);
            mHalted = nHalted; mPend = nPend; mTarget = nTarget;
        end
        #1;
    endtask

    task automatic idle(input bit mw);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0, mw);
    endtask

    // Monitor: independent of stimulus, compares whatever the model predicted for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                if (e.known) begin
                    check("PC", 32'(PC), 32'(e.pc));
                    check("StallCount", 32'(StallCount), 32'(e.cnt));
                end
                check("TakeBranch", 32'(TakeBranch), 32'(e.tb));
                check("TakeJump", 32'(TakeJump), 32'(e.tj));
                check("PCOverwrite", 32'(PCOverwrite), 32'(e.ov));
                check("Halt", 32'(Halt), 32'(e.halt));
                check("Stall", 32'(Stall), 32'(e.stall));
                check("OverwriteAddress", 32'(OverwriteAddress), 32'(e.addr));
                check("FlushIF", 32'(FlushIF), 32'(e.fif));
                check("FlushID", 32'(FlushID), 32'(e.fid));
                check("FlushEX", 32'(FlushEX), 32'(e.fex));
            end else if (stimDone) begin
                break;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        @(posedge Clock);
        #1;
        drive(1'b0, 0, 0, '0, 0, '0, 0, 8'd0, 0, 0, 0, 0);
        drive(1'b0, 0, 0, '0, 0, '0, 0, 8'd0, 0, 0, 0, 0);
        repeat (4) idle(1'b0);
        // Branch beats a simultaneous jump
        drive(1'b1, 1, 1, 8'd10, 1, 8'd55, 0, 8'd0, 0, 0, 0, 0);
        idle(1'b0);
        // Jump under MemWait, replayed after three wait cycles
        drive(1'b1, 0, 0, '0, 1, 8'd78, 0, 8'd0, 0, 0, 0, 1);
        idle(1'b1); idle(1'b1);
        idle(1'b0); idle(1'b0);
        // Exception while pending replaces the target
        drive(1'b1, 0, 0, '0, 1, 8'd78, 0, 8'd0, 0, 0, 0, 1);
        drive(1'b1, 1, 1, 8'd90, 0, '0, 1, 8'd35, 0, 0, 0, 1);
        idle(1'b1); idle(1'b0); idle(1'b0);
        // Halt, ignored jumps, then resume
        drive(1'b1, 0, 0, '0, 0, '0, 0, 8'd0, 1, 0, 0, 0);
        repeat (4) drive(1'b1, 0, 0, '0, 1, 8'd66, 0, 8'd0, 0, 0, 1, 1);
        drive(1'b1, 0, 0, '0, 0, '0, 0, 8'd0, 0, 1, 0, 0);
        idle(1'b0);
        // Reset in the middle of a pending redirect
        drive(1'b1, 0, 0, '0, 1, 8'd44, 0, 8'd0, 0, 0, 0, 1);
        drive(1'b0, 0, 0, '0, 0, '0, 0, 8'd0, 0, 0, 0, 1);
        idle(1'b0); idle(1'b0);
        // Counter saturation
        repeat (270) drive(1'b1, 0, 0, '0, 0, '0, 0, 8'd0, 0, 0, 1, 0);
        idle(1'b0);
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) >= 2,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 1) == 1, DW'($urandom),
                  $urandom_range(0, 99) < 20, DW'($urandom),
                  $urandom_range(0, 99) < 10, DW'($urandom),
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 40);
        end
        stimDone = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: monitor did not drain, expected queue empty");
        $fatal(1, "timeout");
    end

endmodule
